// File: rtl/qep_gen_pkg.sv
// qep_gen_pkg: shared FSM states, quadrature state constants and the A/B step function.
package qep_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN_CONT, RUN_BURST} qep_gen_state_t;
  localparam logic [1:0] QEP_AB_S0 = 2'b00;
  localparam logic [1:0] QEP_AB_S1 = 2'b10;
  localparam logic [1:0] QEP_AB_S2 = 2'b11;
  localparam logic [1:0] QEP_AB_S3 = 2'b01;
  localparam int QEP_GEN_MIN_PERIOD = 2;
  function automatic logic [1:0] qep_ab_next(input logic [1:0] ab, input logic fwd);
    return fwd ? (ab == QEP_AB_S0 ? QEP_AB_S1 : ab == QEP_AB_S1 ? QEP_AB_S2 : ab == QEP_AB_S2 ? QEP_AB_S3 : QEP_AB_S0)
               : (ab == QEP_AB_S0 ? QEP_AB_S3 : ab == QEP_AB_S3 ? QEP_AB_S2 : ab == QEP_AB_S2 ? QEP_AB_S1 : QEP_AB_S0);
  endfunction
endpackage

// File: rtl/qep_gen_quad_stepper.sv
// qep_gen_quad_stepper: A/B state, wrapping position, index compare and position preset.
module qep_gen_quad_stepper
  import qep_gen_pkg::*;
#(
  parameter int P_POS_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step,
  input  logic                   dir,
  input  logic                   load,
  input  logic [P_POS_WIDTH-1:0] load_value,
  input  logic [P_POS_WIDTH-1:0] max_count,
  input  logic [P_POS_WIDTH-1:0] index_pos,
  output logic                   qep_a,
  output logic                   qep_b,
  output logic                   qep_i,
  output logic                   pulse_out,
  output logic                   dir_out,
  output logic [P_POS_WIDTH-1:0] position
);
  logic [1:0] ab;
  logic adv;
  logic [P_POS_WIDTH-1:0] pos_step, pos_nx;
  // a preset wins over a coincident edge, which is then dropped
  assign adv = step && !load;
  assign pos_step = dir ? (position == max_count ? '0 : position + 1'b1)
                        : (position == '0 ? max_count : position - 1'b1);
  assign pos_nx = load ? load_value : adv ? pos_step : position;
  assign {qep_a, qep_b} = ab;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ab <= QEP_AB_S0;
      position <= '0;
      qep_i <= 1'b0;
      pulse_out <= 1'b0;
      dir_out <= 1'b0;
    end else begin
      ab <= adv ? qep_ab_next(ab, dir) : ab;
      position <= pos_nx;
      qep_i <= pos_nx == index_pos && index_pos <= max_count;
      pulse_out <= adv;
      dir_out <= adv ? dir : dir_out;
    end
endmodule

// File: rtl/qep_signal_gen.sv
// qep_signal_gen: quadrature encoder emulator producing A/B/I and pulse/dir at a programmable edge rate.
// Define QEP_GEN_BURST_EN to compile in the burst command handshake.
module qep_signal_gen
  import qep_gen_pkg::*;
#(
  parameter int P_DIV_WIDTH = 16,
  parameter int P_POS_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   dir,
  input  logic [P_DIV_WIDTH-1:0] period,
  input  logic [P_POS_WIDTH-1:0] max_count,
  input  logic [P_POS_WIDTH-1:0] index_pos,
  input  logic                   pos_load,
  input  logic [P_POS_WIDTH-1:0] load_value,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [P_POS_WIDTH-1:0] cmd_steps,
  input  logic                   cmd_dir,
  output logic                   qep_a,
  output logic                   qep_b,
  output logic                   qep_i,
  output logic                   pulse_out,
  output logic                   dir_out,
  output logic [P_POS_WIDTH-1:0] position,
  output logic                   busy,
  output logic                   done
);
  qep_gen_state_t state, state_n;
  logic [P_DIV_WIDTH-1:0] div_cnt, per_q, eff_period;
  logic dir_q, dir_sel, fire, step, accept, burst_go, last_step;
  assign eff_period = period < P_DIV_WIDTH'(QEP_GEN_MIN_PERIOD) ? P_DIV_WIDTH'(QEP_GEN_MIN_PERIOD) : period;
  // dropping enable in continuous mode discards the pending edge
  assign fire = (state == RUN_BURST || (state == RUN_CONT && enable)) && div_cnt == per_q - 1'b1;
  assign step = fire && !pos_load;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = burst_go ? RUN_BURST : (enable && !accept) ? RUN_CONT : IDLE;
    else if (state == RUN_CONT) state_n = enable ? RUN_CONT : IDLE;
    else state_n = last_step ? IDLE : RUN_BURST;
  end
  // period and direction are latched per interval so changes land on the next one
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      div_cnt <= '0;
      per_q <= P_DIV_WIDTH'(QEP_GEN_MIN_PERIOD);
      dir_q <= 1'b0;
    end else begin
      state <= state_n;
      div_cnt <= (state == IDLE || pos_load || fire) ? '0 : div_cnt + 1'b1;
      if (state == IDLE || step) begin
        per_q <= eff_period;
        dir_q <= dir_sel;
      end
    end
`ifdef QEP_GEN_BURST_EN
  logic [P_POS_WIDTH-1:0] rem;
  assign accept = cmd_valid && cmd_ready;
  assign burst_go = accept && cmd_steps != '0;
  assign last_step = state == RUN_BURST && step && rem == P_POS_WIDTH'(1);
  assign dir_sel = state == RUN_BURST ? dir_q : burst_go ? cmd_dir : dir;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rem <= '0;
      cmd_ready <= 1'b0;
      done <= 1'b0;
    end else begin
      rem <= burst_go ? cmd_steps : (state == RUN_BURST && step) ? rem - 1'b1 : rem;
      cmd_ready <= state_n == IDLE && !enable;
      done <= (accept && cmd_steps == '0) || last_step;
    end
`else
  logic unused_cmd;
  assign unused_cmd = ^{cmd_valid, cmd_steps, cmd_dir};
  assign accept = 1'b0;
  assign burst_go = 1'b0;
  assign last_step = 1'b0;
  assign dir_sel = dir;
  assign cmd_ready = 1'b0;
  assign done = 1'b0;
`endif
  qep_gen_quad_stepper #(.P_POS_WIDTH(P_POS_WIDTH)) u_stepper (
    .clk(clk),
    .reset(reset),
    .step(fire),
    .dir(dir_q),
    .load(pos_load),
    .load_value(load_value),
    .max_count(max_count),
    .index_pos(index_pos),
    .qep_a(qep_a),
    .qep_b(qep_b),
    .qep_i(qep_i),
    .pulse_out(pulse_out),
    .dir_out(dir_out),
    .position(position)
  );
endmodule

// File: tb/tb_qep_signal_gen.sv
// tb_qep_signal_gen: randomized self-checking bench with an edge-schedule reference model.
module tb_qep_signal_gen;
`ifdef QEP_GEN_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  logic clk = 0, reset = 1, enable = 0, dir = 0, pos_load = 0, cmd_valid = 0, cmd_dir = 0;
  logic [15:0] period = 16'd4;
  logic [31:0] max_count = 32'd7, index_pos = 0, load_value = 0, cmd_steps = 0;
  logic cmd_ready, qep_a, qep_b, qep_i, pulse_out, dir_out, busy, done;
  logic [31:0] position;
  int total = 0, bad = 0, cyc = 0;
  int m_st, m_phase, m_len, m_due;
  logic [31:0] m_pos, m_rem;
  bit m_pulse, m_dout, m_i, m_done, m_ready, m_dir;

  always #5 clk = ~clk;

  qep_signal_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .period(period),
    .max_count(max_count), .index_pos(index_pos), .pos_load(pos_load), .load_value(load_value),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps), .cmd_dir(cmd_dir),
    .qep_a(qep_a), .qep_b(qep_b), .qep_i(qep_i), .pulse_out(pulse_out), .dir_out(dir_out),
    .position(position), .busy(busy), .done(done)
  );

  function automatic logic [31:0] step_pos(logic [31:0] p, bit fwd, logic [31:0] mx);
    if (fwd) return p == mx ? 32'd0 : p + 32'd1;
    return p == 0 ? mx : p - 32'd1;
  endfunction
  function automatic int eff(logic [15:0] p);
    return p < 16'd2 ? 2 : int'(p);
  endfunction
  function automatic logic [1:0] ab_of(int ph);
    return ph == 0 ? 2'b00 : ph == 1 ? 2'b10 : ph == 2 ? 2'b11 : 2'b01;
  endfunction
  function automatic logic [39:0] exp_vec();
    return {ab_of(m_phase), m_i, m_pulse, m_dout, m_st != 0, m_done, m_ready, m_pos};
  endfunction
  function automatic logic [39:0] obs_vec();
    return {qep_a, qep_b, qep_i, pulse_out, dir_out, busy, done, cmd_ready, position};
  endfunction

  task automatic model_reset();
    m_st = 0; m_phase = 0; m_len = 2; m_due = -1; m_pos = 0; m_rem = 0;
    m_pulse = 0; m_dout = 0; m_i = 0; m_done = 0; m_ready = 0; m_dir = 0;
  endtask

  // one clock: predict from the inputs held across the edge, then sample 1 time unit later
  task automatic tick();
    bit fire, adv, acc, dn, ni;
    int ns;
    logic [31:0] np;
    fire = (m_st == 2 || (m_st == 1 && enable)) && cyc == m_due;
    adv = fire && !pos_load;
    acc = BURST && cmd_valid && m_ready;
    np = pos_load ? load_value : adv ? step_pos(m_pos, m_dir, max_count) : m_pos;
    ni = np == index_pos && index_pos <= max_count;
    dn = (acc && cmd_steps == 0) || (m_st == 2 && adv && m_rem == 1);
    ns = m_st;
    if (adv) begin
      m_phase = (m_phase + (m_dir ? 1 : 3)) % 4;
      m_dout = m_dir;
    end
    if (m_st == 0) begin
      m_len = eff(period);
      m_due = cyc + m_len;
      if (acc && cmd_steps != 0) begin ns = 2; m_rem = cmd_steps; m_dir = cmd_dir; end
      else if (!acc && enable) begin ns = 1; m_dir = dir; end
    end else if (m_st == 1 && !enable) ns = 0;
    else if (adv) begin
      if (m_st == 2) m_rem = m_rem - 1;
      if (m_st == 2 && m_rem == 0) ns = 0;
      else begin
        m_len = eff(period);
        m_due = cyc + m_len;
        if (m_st == 1) m_dir = dir;
      end
    end else if (pos_load) m_due = cyc + m_len;
    @(posedge clk);
    #1;
    cyc++;
    m_st = ns; m_pos = np; m_pulse = adv; m_done = dn; m_i = ni;
    m_ready = BURST && ns == 0 && !enable;
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; cmd_valid = 0; pos_load = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    total++;
    if (obs_vec() !== 40'h0) begin bad++; $display("FAIL reset_hold got=%h want=0", obs_vec()); end
    reset = 0;
    tick();
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL reset_release got=%h want=%h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_forward();
    int pc[$];
    logic [1:0] abq[$];
    logic [1:0] want_ab[4];
    want_ab[0] = 2'b10; want_ab[1] = 2'b11; want_ab[2] = 2'b01; want_ab[3] = 2'b00;
    period = 4; max_count = 7; index_pos = 0; dir = 1; enable = 1;
    for (int n = 0; n < 40; n++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL fwd cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec()); end
      if (pulse_out) begin pc.push_back(cyc); abq.push_back({qep_a, qep_b}); end
    end
    total++;
    if (pc.size() < 9) begin bad++; $display("FAIL fwd_pulse_count got=%0d want=9", pc.size()); end
    for (int k = 1; k < pc.size(); k++) begin
      total++;
      if (pc[k] - pc[k-1] !== 4) begin bad++; $display("FAIL fwd_spacing got=%0d want=4", pc[k] - pc[k-1]); end
    end
    for (int k = 0; k < 4 && k < abq.size(); k++) begin
      total++;
      if (abq[k] !== want_ab[k]) begin bad++; $display("FAIL fwd_ab%0d got=%b want=%b", k, abq[k], want_ab[k]); end
    end
  endtask

  task automatic test_reverse();
    bit wrapped = 0;
    logic [31:0] prev = position;
    dir = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rev cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec()); end
      if (pulse_out && !dir_out && prev == 0 && position == 7) wrapped = 1;
      if (pulse_out) prev = position;
    end
    total++;
    if (wrapped !== 1'b1) begin bad++; $display("FAIL rev_wrap got=%0b want=1", wrapped); end
  endtask

  task automatic test_pos_load();
    logic [1:0] ab0;
    int k;
    dir = 1; enable = 1;
    for (int w = 0; w < 20 && cyc != m_due; w++) tick();
    ab0 = {qep_a, qep_b};
    pos_load = 1; load_value = 32'h10;
    tick();
    pos_load = 0;
    total++;
    if ({position, pulse_out, qep_a, qep_b} !== {32'h10, 1'b0, ab0})
      begin bad++; $display("FAIL load got pos=%h pulse=%b ab=%b want pos=10 pulse=0 ab=%b", position, pulse_out, {qep_a, qep_b}, ab0); end
    k = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL load_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec()); end
      if (pulse_out && k == 0) k = n;
    end
    total++;
    if (k !== 4) begin bad++; $display("FAIL load_next_edge got=%0d want=4", k); end
  endtask

  task automatic test_enable_drop();
    int p = 0;
    enable = 1;
    for (int w = 0; w < 20 && cyc != m_due - 2; w++) tick();
    enable = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL en_drop cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec()); end
      p += int'(pulse_out);
    end
    total++;
    if (p !== 0) begin bad++; $display("FAIL en_drop_pulses got=%0d want=0", p); end
  endtask

  task automatic test_random();
    int edges = 0;
    max_count = $urandom_range(3, 20);
    index_pos = $urandom_range(0, max_count + 2);
    pos_load = 1; load_value = 0; enable = 1;
    tick();
    pos_load = 0;
    for (int n = 0; n < 20000 && edges < 1000; n++) begin
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 31) == 0) period = 16'($urandom_range(0, 5));
      pos_load = $urandom_range(0, 63) == 0;
      load_value = $urandom_range(0, max_count);
      enable = $urandom_range(0, 99) != 0;
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rand cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec()); end
      edges += int'(pulse_out);
    end
    pos_load = 0; enable = 0;
    total++;
    if (edges < 1000) begin bad++; $display("FAIL rand_edges got=%0d want=1000", edges); end
    tick();
  endtask

`ifdef QEP_GEN_BURST_EN
  task automatic test_burst();
    int pc[$];
    int dc = -1, rdy = 0;
    enable = 0; period = 3; max_count = 7; index_pos = 2;
    tick(); tick();
    cmd_valid = 1; cmd_steps = 5; cmd_dir = 1;
    tick();
    cmd_valid = 0;
    for (int n = 0; n < 30; n++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL burst cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec()); end
      if (dc >= 0 && cyc == dc + 1) rdy = int'(cmd_ready);
      if (pulse_out) pc.push_back(cyc);
      if (done) dc = cyc;
    end
    total++;
    if (pc.size() !== 5) begin bad++; $display("FAIL burst_pulses got=%0d want=5", pc.size()); end
    for (int k = 1; k < pc.size(); k++) begin
      total++;
      if (pc[k] - pc[k-1] !== 3) begin bad++; $display("FAIL burst_spacing got=%0d want=3", pc[k] - pc[k-1]); end
    end
    total++;
    if (pc.size() != 5 || dc !== pc[4]) begin bad++; $display("FAIL burst_done_cycle got=%0d want=fifth edge", dc); end
    total++;
    if (rdy !== 1) begin bad++; $display("FAIL burst_ready_after got=%0d want=1", rdy); end
    cmd_valid = 1; cmd_steps = 0;
    tick();
    cmd_valid = 0;
    total++;
    if ({done, busy} !== 2'b10) begin bad++; $display("FAIL zero_done got=%b want=10", {done, busy}); end
    tick();
    total++;
    if (obs_vec() !== exp_vec() || done !== 1'b0) begin bad++; $display("FAIL zero_after got=%h want=%h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_reset_mid_burst();
    period = 2; cmd_valid = 1; cmd_steps = 20; cmd_dir = 0;
    tick();
    cmd_valid = 0;
    repeat (7) tick();
    reset = 1;
    #2;
    total++;
    if (obs_vec() !== 40'h0) begin bad++; $display("FAIL burst_async_reset got=%h want=0", obs_vec()); end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec() || done !== 1'b0) begin bad++; $display("FAIL burst_post_reset cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec()); end
    end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL burst_ready_reset got=%b want=1", cmd_ready); end
  endtask
`else
  task automatic test_burst_disabled();
    enable = 0; cmd_valid = 1; cmd_steps = 3; cmd_dir = 1;
    for (int n = 0; n < 10; n++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL no_burst cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec()); end
    end
    cmd_valid = 0;
    total++;
    if ({cmd_ready, done, busy} !== 3'b000) begin bad++; $display("FAIL no_burst_ports got=%b want=000", {cmd_ready, done, busy}); end
  endtask
`endif

  task automatic test_reset_mid_run();
    period = 3; dir = 1; enable = 1;
    repeat (10) tick();
    reset = 1;
    #2;
    total++;
    if (obs_vec() !== 40'h0) begin bad++; $display("FAIL run_async_reset got=%h want=0", obs_vec()); end
    model_reset();
    enable = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL run_post_reset cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_pos_load();
    test_enable_drop();
    test_random();
`ifdef QEP_GEN_BURST_EN
    test_burst();
    test_reset_mid_burst();
`else
    test_burst_disabled();
`endif
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/qep_signal_gen.md
# qep_signal_gen

Quadrature encoder emulator: the transmit end of the QEP interface. It synthesises A/B/I encoder signals, plus the matching single-edge pulse/dir stream, at a programmable edge rate. It sits on the drive-subsystem side of the QEP pins and drives the counter's `pulse`/`dir`/`index` inputs, for loopback self-test and for hardware-in-the-loop motor emulation. The position model wraps exactly as the receiving counter does, so the two positions track one-for-one.

## Interface
- `P_DIV_WIDTH`, 16: width of `period`.
- `P_POS_WIDTH`, 32: width of `position`, `max_count`, `index_pos`, `load_value`, `cmd_steps` (1..32).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: continuous-run request.
- `dir` in 1: continuous-mode direction; 1 = forward (receiver counts up).
- `period` in P_DIV_WIDTH: clocks per quadrature edge; values < 2 are treated as 2.
- `max_count` in P_POS_WIDTH: last position before wrap.
- `index_pos` in P_POS_WIDTH: position at which `qep_i` is high.
- `pos_load` in 1, `load_value` in P_POS_WIDTH: synchronous position preset.
- `cmd_valid` in 1, `cmd_ready` out 1, `cmd_steps` in P_POS_WIDTH, `cmd_dir` in 1: burst command handshake.
- `qep_a`, `qep_b`, `qep_i` out 1: registered encoder outputs.
- `pulse_out` out 1: one-cycle high per edge.
- `dir_out` out 1: direction of the last edge.
- `position` out P_POS_WIDTH: emitted edge count.
- `busy` out 1: generator running.
- `done` out 1: one-cycle burst-complete strobe.

## Operation
- FSM states: IDLE, RUN_CONT, RUN_BURST.
  - IDLE→RUN_CONT when `enable`=1.
  - RUN_CONT→IDLE when `enable`=0.
  - IDLE→RUN_BURST on a command accept.
  - RUN_BURST→IDLE after the final step.
- Divider `div_cnt` counts 0..eff_period-1 while running. It clears in IDLE, on entry to any run state, and on `pos_load`. An edge fires when `div_cnt`==eff_period-1.
- `period` and the active direction are sampled at each edge, so a change applies to the next interval.
- Quadrature sequence {A,B}:
  - Forward: 00→10→11→01→00 (A leads).
  - Reverse: the exact inverse.
  - A direction reversal steps backward from the current state. A and B never change in the same cycle.
- Position update on each edge:
  - Forward: `max_count`→0, otherwise +1.
  - Reverse: 0→`max_count`, otherwise −1.
- `qep_i` is registered as (next position == `index_pos`). If `index_pos` > `max_count`, `qep_i` never asserts.
- `pulse_out` is high for exactly the edge-update cycle. Because eff_period ≥ 2, at least one low cycle separates consecutive pulses. `dir_out` updates in the same cycle.
- `pos_load` has priority over an edge in the same cycle: the edge is dropped, `position` takes `load_value`, the A/B state is held, and `qep_i` is re-evaluated.
- A burst commands exactly `cmd_steps` edges in direction `cmd_dir`; `enable` and `dir` are ignored during RUN_BURST.
  - `cmd_ready` = (state==IDLE && !enable). A command is accepted when `cmd_valid` && `cmd_ready`.
  - `cmd_steps`=0: `done` pulses the next cycle and the FSM stays in IDLE.
  - Otherwise the remaining-step count decrements on each edge. `done` pulses in the same cycle as the final edge's outputs.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - A, B, I, `pulse_out`, `dir_out`, `busy`, `done`, `cmd_ready`: 0.
  - `position`: 0.
  - FSM: IDLE.
- `enable` rising at cycle t → RUN_CONT at t+1 → first edge outputs visible at t+1+eff_period.
- All outputs are registered; no combinational input-to-output path.
- `enable` dropping mid-interval: the pending edge is discarded and outputs hold their values.
- Reset mid-operation: returns immediately to the reset values; any pending burst is lost and no `done` is issued.

## Configuration
- `QEP_GEN_BURST_EN` defined: the burst handshake, RUN_BURST state and remaining-step counter are compiled in.
- Not defined: the ports remain, `cmd_ready` and `done` are tied to 0, and `cmd_*` inputs are ignored. The FSM reduces to IDLE/RUN_CONT.

## Structure
- Package `qep_gen_pkg`: FSM state enum, 2-bit quadrature state constants, `QEP_GEN_MIN_PERIOD`=2.
- Sub-module `qep_gen_quad_stepper`: takes an edge strobe and direction; owns the A/B state, position wrap, index compare and load. The top level holds the FSM, the divider and the burst counter.

## Test plan
- `period`=4, `max_count`=7, `dir`=1, `enable` held → an edge every 4 clocks; AB sequence 00,10,11,01; `position` runs 0..7 then 0; `qep_i` high only while `position`=`index_pos`=0.
- Continuous forward then `dir`=0 mid-run → AB reverses from its current state, `position` decrements, and 0→7 wrap is verified.
- Loopback into the QEP counter (`max_count` matched, `pulse_out`/`dir_out`/`qep_i` connected) for 1000 random-direction edges → receiver count equals `position` at every edge.
- Burst with `cmd_steps`=5, `cmd_dir`=1, `period`=3 → five pulses 3 clocks apart, `done` coincides with the fifth edge, `cmd_ready` returns high the next cycle; `cmd_steps`=0 → `done` pulses one cycle after accept.
- `pos_load` with `load_value`=0x10 on the same cycle as an edge → `position`=0x10, AB unchanged, no `pulse_out`, next edge 4 clocks later.
- Reset asserted mid-burst → all outputs 0 asynchronously; no `done`; `cmd_ready`=1 after reset releases.
